// File: rtl/eeprom_ctrl_if.sv
// Host-side command/response channel of the EEPROM sequencer.
// The host drives commands with valid/ready, and the controller returns
// one response per command on a second valid/ready channel.
interface eeprom_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/eeprom_ctrl.sv
// Initiator-side sequencer for a level-sensitive EEPROM array.
// Read: READ -> RESP. Program: ERASE -> WRITE -> READ (verify) -> RESP.
// Erase: ERASE -> READ (blank check) -> RESP. Reserved op: straight to RESP.
// Strobes are registered from the next state, so a phase change swaps
// strobes on a single edge with no idle cycle in between.
module eeprom_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16,
  parameter int ERASE_CYCLES = 4,
  parameter int WRITE_CYCLES = 4,
  parameter int READ_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  eeprom_ctrl_if.slave      host,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_erase,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_MAX = max3(ERASE_CYCLES, WRITE_CYCLES, READ_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);

  // Verify rule applied to the word sampled at the end of the read phase.
  function automatic logic verify_fail(input op_e op,
                                       input logic [DATA_W-1:0] rd,
                                       input logic [DATA_W-1:0] wd);
    case (op)
      OP_PROG:  return rd != wd;
      OP_ERASE: return rd != '0;
      default:  return 1'b0;
    endcase
  endfunction

  state_e            state, state_d;
  op_e               op_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              read_done;
  logic              rsp_hs;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign host.cmd_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign host.rsp_err   = rsp_err_q;

  assign accept    = (state == S_IDLE) && host.cmd_valid;
  assign read_done = (state == S_READ) && (cnt == READ_LAST);
  assign rsp_hs    = rsp_valid_q && host.rsp_ready;

  // Next-state decode; each timed phase leaves on its last counted cycle.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          unique case (op_e'(host.cmd_op))
            OP_READ:  state_d = S_READ;
            OP_PROG:  state_d = S_ERASE;
            OP_ERASE: state_d = S_ERASE;
            OP_RSVD:  state_d = S_RESP;
          endcase
        end
      end
      S_ERASE: if (cnt == ERASE_LAST) state_d = (op_q == OP_PROG) ? S_WRITE : S_READ;
      S_WRITE: if (cnt == WRITE_LAST) state_d = S_READ;
      S_READ:  if (cnt == READ_LAST)  state_d = S_RESP;
      S_RESP:  if (rsp_hs)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, phase counter and registered array strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_erase <= 1'b0;
    end else begin
      state     <= state_d;
      mem_erase <= (state_d == S_ERASE);
      mem_we    <= (state_d == S_WRITE);
      if ((state_d == state) &&
          (state == S_ERASE || state == S_WRITE || state == S_READ))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Command latch: address and data stay put for the whole command and in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      op_q      <= op_e'(host.cmd_op);
      mem_addr  <= host.cmd_addr;
      mem_wdata <= host.cmd_wdata;
    end
  end

  // Response register: filled at the last read edge (or on a reserved op),
  // held until the host handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept && op_e'(host.cmd_op) == OP_RSVD) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end
      if (read_done) begin
        rsp_rdata_q <= mem_rdata;
        rsp_err_q   <= verify_fail(op_q, mem_rdata, mem_wdata);
      end
      if (rsp_hs)
        rsp_valid_q <= 1'b0;
      else if (read_done || state == S_RESP)
        rsp_valid_q <= 1'b1;
    end
  end

endmodule
